// File: rtl/tx_lane_scheduler.sv
// TX lane scheduler: one owner per packet among OS, CTL and TP.
// OS wins outright; TP jumps ahead of CTL after waiting too long.
module tx_lane_scheduler #(
  parameter int DATA_W       = 8,
  parameter int MAX_PKT      = 64,
  parameter int STARVE_LIMIT = 32
) (
  input  logic              local_clk,
  input  logic              rst,
  input  logic              cl0_s,
  input  logic              lane_disable,
  input  logic              os_req,
  input  logic              os_last,
  input  logic [DATA_W-1:0] os_data,
  input  logic              ctl_req,
  input  logic              ctl_last,
  input  logic [DATA_W-1:0] ctl_data,
  input  logic              tp_req,
  input  logic              tp_last,
  input  logic [DATA_W-1:0] tp_data,
  output logic              os_gnt,
  output logic              ctl_gnt,
  output logic              tp_gnt,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic [1:0]        tx_src,
  output logic              abort,
  output logic              busy
);

  localparam int BW = $clog2(MAX_PKT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] BLAST = BW'(MAX_PKT - 1);
  localparam logic [SW-1:0] SMAX  = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OS,
    S_CTL,
    S_TP
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [BW-1:0]     beat_cnt;
  logic [SW-1:0]     starve_cnt;
  logic              gnt_any;
  logic              gnt_last;
  logic [DATA_W-1:0] gnt_data;
  logic [1:0]        gnt_src;
  logic              pkt_full;
  logic              max_abort;
  logic              tp_entry;

  assign os_gnt  = (state == S_OS)  & os_req  & ~lane_disable;
  assign ctl_gnt = (state == S_CTL) & ctl_req & ~lane_disable;
  assign tp_gnt  = (state == S_TP)  & tp_req  & ~lane_disable;
  assign busy    = (state != S_IDLE);

  assign pkt_full  = (beat_cnt == BLAST);
  assign max_abort = gnt_any & ~gnt_last & pkt_full;
  assign tp_entry  = (state == S_IDLE) & (nxt == S_TP);

  // Select the beat of whichever source holds the grant
  always_comb begin
    gnt_any  = 1'b0;
    gnt_last = 1'b0;
    gnt_data = '0;
    gnt_src  = 2'b00;
    unique case (1'b1)
      os_gnt: begin
        gnt_any  = 1'b1;
        gnt_last = os_last;
        gnt_data = os_data;
        gnt_src  = 2'b01;
      end
      ctl_gnt: begin
        gnt_any  = 1'b1;
        gnt_last = ctl_last;
        gnt_data = ctl_data;
        gnt_src  = 2'b10;
      end
      tp_gnt: begin
        gnt_any  = 1'b1;
        gnt_last = tp_last;
        gnt_data = tp_data;
        gnt_src  = 2'b11;
      end
      default: ;
    endcase
  end

  // Owner selection in IDLE; packet end, overflow or disable back to IDLE
  always_comb begin
    nxt = state;
    if (lane_disable) begin
      nxt = S_IDLE;
    end else if (state == S_IDLE) begin
      if (os_req)
        nxt = S_OS;
      else if (cl0_s && tp_req && starve_cnt >= SMAX)
        nxt = S_TP;
      else if (cl0_s && ctl_req)
        nxt = S_CTL;
      else if (cl0_s && tp_req)
        nxt = S_TP;
    end else if (gnt_any && (gnt_last || pkt_full)) begin
      nxt = S_IDLE;
    end
  end

  // State register
  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  // Beats of the current packet; zero whenever we are (re)entering IDLE
  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst)                beat_cnt <= '0;
    else if (nxt == S_IDLE)  beat_cnt <= '0;
    else if (gnt_any)        beat_cnt <= beat_cnt + BW'(1);
  end

  // Cycles TP has been kept waiting, saturating at the promotion limit
  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst)
      starve_cnt <= '0;
    else if (lane_disable || !tp_req || tp_entry)
      starve_cnt <= '0;
    else if (state != S_TP && starve_cnt != SMAX)
      starve_cnt <= starve_cnt + SW'(1);
  end

  // Registered output beat and abort pulse
  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
      tx_src   <= 2'b00;
      abort    <= 1'b0;
    end else begin
      tx_valid <= gnt_any;
      tx_data  <= gnt_data;
      tx_src   <= gnt_src;
      abort    <= max_abort | (lane_disable & busy);
    end
  end

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Directed bench for tx_lane_scheduler with a cycle-level
// reference model and literal scenario expectations.
`timescale 1ns/1ps
module tb_tx_lane_scheduler;

  localparam int DW   = 8;
  localparam int MAXP = 64;
  localparam int LIM  = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cl0_s = 1'b0;
  logic lane_disable = 1'b0;
  logic os_req = 1'b0, os_last = 1'b0;
  logic ctl_req = 1'b0, ctl_last = 1'b0;
  logic tp_req = 1'b0, tp_last = 1'b0;
  logic [DW-1:0] os_data = '0, ctl_data = '0, tp_data = '0;
  logic os_gnt, ctl_gnt, tp_gnt;
  logic tx_valid, abort, busy;
  logic [DW-1:0] tx_data;
  logic [1:0] tx_src;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tx_lane_scheduler #(
    .DATA_W(DW), .MAX_PKT(MAXP), .STARVE_LIMIT(LIM)
  ) dut (
    .local_clk(clk), .rst(rst),
    .cl0_s(cl0_s), .lane_disable(lane_disable),
    .os_req(os_req), .os_last(os_last), .os_data(os_data),
    .ctl_req(ctl_req), .ctl_last(ctl_last), .ctl_data(ctl_data),
    .tp_req(tp_req), .tp_last(tp_last), .tp_data(tp_data),
    .os_gnt(os_gnt), .ctl_gnt(ctl_gnt), .tp_gnt(tp_gnt),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_src(tx_src),
    .abort(abort), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic req_of(input int s);
    case (s)
      1: return os_req;
      2: return ctl_req;
      3: return tp_req;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic last_of(input int s);
    case (s)
      1: return os_last;
      2: return ctl_last;
      3: return tp_last;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [DW-1:0] data_of(input int s);
    case (s)
      1: return os_data;
      2: return ctl_data;
      3: return tp_data;
      default: return '0;
    endcase
  endfunction

  function automatic logic gnt_of(input int s);
    case (s)
      1: return os_gnt;
      2: return ctl_gnt;
      3: return tp_gnt;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: owner 0 = nobody, 1 = OS, 2 = CTL, 3 = TP
  int m_owner = 0, m_next = 0, m_beats = 0, m_wait = 0, m_g = 0;
  logic e_valid = 1'b0, e_abort = 1'b0;
  logic [DW-1:0] e_data = '0;
  logic [1:0] e_src = 2'b00;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = 0; m_beats = 0; m_wait = 0;
      e_valid = 1'b0; e_abort = 1'b0;
      e_data = '0; e_src = 2'b00;
    end else begin
      m_g = 0;
      if (!lane_disable && m_owner != 0 && req_of(m_owner))
        m_g = m_owner;
      e_valid = (m_g != 0);
      e_data  = (m_g != 0) ? data_of(m_g) : '0;
      e_src   = 2'(m_g);
      e_abort = 1'b0;
      if (lane_disable) begin
        e_abort = (m_owner != 0);
        m_owner = 0; m_beats = 0; m_wait = 0;
      end else begin
        m_next = m_owner;
        if (m_owner == 0) begin
          if (os_req) m_next = 1;
          else if (cl0_s && tp_req && m_wait >= LIM) m_next = 3;
          else if (cl0_s && ctl_req) m_next = 2;
          else if (cl0_s && tp_req) m_next = 3;
        end else if (m_g != 0) begin
          m_beats++;
          if (last_of(m_g)) m_next = 0;
          else if (m_beats == MAXP) begin
            m_next = 0;
            e_abort = 1'b1;
          end
        end
        if (!tp_req || (m_owner == 0 && m_next == 3)) m_wait = 0;
        else if (m_owner != 3 && m_wait < LIM) m_wait++;
        if (m_next == 0) m_beats = 0;
        m_owner = m_next;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("os_gnt", os_gnt, m_owner == 1 && os_req && !lane_disable);
    check("ctl_gnt", ctl_gnt, m_owner == 2 && ctl_req && !lane_disable);
    check("tp_gnt", tp_gnt, m_owner == 3 && tp_req && !lane_disable);
    check("tx_valid", tx_valid, e_valid);
    check("tx_data", tx_data, e_data);
    check("tx_src", tx_src, e_src);
    check("abort", abort, e_abort);
    check("busy", busy, m_owner != 0);
  end

  // Scenario monitor
  int n_os, n_ctl_pre, n_tp, n_valid, n_abort;
  logic busy_at_abort, tp_seen, ctl_at_tp;
  logic [1:0] src_log[$];
  bit rec = 1'b0;

  always @(negedge clk) begin
    if (os_gnt) n_os++;
    if (tp_gnt) n_tp++;
    if (tx_valid) n_valid++;
    if (ctl_gnt && !tp_seen) n_ctl_pre++;
    if (tp_gnt && !tp_seen) begin
      tp_seen = 1'b1;
      ctl_at_tp = ctl_req;
    end
    if (abort) begin
      n_abort++;
      busy_at_abort = busy;
    end
    if (rec) src_log.push_back(tx_src);
  end

  task automatic clr_mon();
    n_os = 0; n_ctl_pre = 0; n_tp = 0; n_valid = 0; n_abort = 0;
    busy_at_abort = 1'b1; tp_seen = 1'b0; ctl_at_tp = 1'b0;
    src_log.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_src(input int s, input logic r, input logic l,
                         input logic [DW-1:0] d);
    case (s)
      1: begin os_req = r; os_last = l; os_data = d; end
      2: begin ctl_req = r; ctl_last = l; ctl_data = d; end
      3: begin tp_req = r; tp_last = l; tp_data = d; end
      default: ;
    endcase
  endtask

  // Offer n beats; each beat held until granted (bounded wait)
  task automatic drive_pkt(input int s, input int n, input bit use_last,
                           input logic [DW-1:0] base);
    int guard;
    for (int b = 0; b < n; b++) begin
      set_src(s, 1'b1, use_last && b == n - 1, base + DW'(b));
      #1;
      guard = 0;
      while (!gnt_of(s) && guard < 300) begin
        @(posedge clk);
        #3;
        guard++;
      end
      check("grant_seen", gnt_of(s), 1'b1);
      tick();
    end
    set_src(s, 1'b0, 1'b0, '0);
  endtask

  logic [1:0] exp_seq [5] = '{2'b10, 2'b10, 2'b00, 2'b11, 2'b11};

  initial begin
    int first;
    int cnt01;
    int cnt11;
    clr_mon();
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_valid", tx_valid, 1'b0);
    check("rst_src", tx_src, 2'b00);
    check("rst_data", tx_data, 8'h00);
    check("rst_abort", abort, 1'b0);
    rst = 1'b1;
    tick();

    // OS packet with cl0_s low and TP waiting
    clr_mon();
    rec = 1'b1;
    cl0_s = 1'b0;
    tp_req = 1'b1;
    tp_data = 8'hEE;
    drive_pkt(1, 4, 1'b1, 8'hA0);
    tp_req = 1'b0;
    tick(); tick();
    rec = 1'b0;
    cnt01 = 0; cnt11 = 0;
    foreach (src_log[i]) begin
      if (src_log[i] == 2'b01) cnt01++;
      if (src_log[i] == 2'b11) cnt11++;
    end
    check("os4_grants", n_os, 4);
    check("os4_tp_grants", n_tp, 0);
    check("os4_src01", cnt01, 4);
    check("os4_src11", cnt11, 0);

    // CTL and TP together: CTL first, gap, then TP
    clr_mon();
    cl0_s = 1'b1;
    rec = 1'b1;
    fork
      drive_pkt(2, 2, 1'b1, 8'h20);
      drive_pkt(3, 2, 1'b1, 8'h30);
    join
    tick(); tick();
    rec = 1'b0;
    first = -1;
    foreach (src_log[i])
      if (first < 0 && src_log[i] != 2'b00) first = i;
    for (int k = 0; k < 5; k++) begin
      if (first >= 0 && first + k < src_log.size())
        check("seq_src", src_log[first + k], exp_seq[k]);
      else
        check("seq_src", 32'hFF, exp_seq[k]);
    end

    // TP starvation promotion behind back-to-back CTL
    clr_mon();
    fork
      begin
        for (int k = 0; k < 13; k++)
          drive_pkt(2, 2, 1'b1, 8'(8'h40 + 2 * k));
      end
      drive_pkt(3, 1, 1'b1, 8'h55);
    join
    tick(); tick();
    check("starve_ctl_beats_before_tp", n_ctl_pre, 22);
    check("starve_ctl_pending", ctl_at_tp, 1'b1);

    // 64-beat TP packet without last: overflow abort
    clr_mon();
    drive_pkt(3, 64, 1'b0, 8'h00);
    tick(); tick();
    check("max_valid_beats", n_valid, 64);
    check("max_tp_grants", n_tp, 64);
    check("max_abort_count", n_abort, 1);
    check("max_busy_at_abort", busy_at_abort, 1'b0);

    // os_req and lane_disable together in IDLE
    clr_mon();
    set_src(1, 1'b1, 1'b1, 8'h11);
    lane_disable = 1'b1;
    #1 check("dis_idle_gnt", os_gnt, 1'b0);
    tick();
    #1 check("dis_idle_busy", busy, 1'b0);
    check("dis_idle_gnt2", os_gnt, 1'b0);
    set_src(1, 1'b0, 1'b0, '0);
    lane_disable = 1'b0;
    tick(); tick();
    check("dis_idle_os", n_os, 0);
    check("dis_idle_abort", n_abort, 0);

    // lane_disable on beat 3 of an OS packet
    clr_mon();
    set_src(1, 1'b1, 1'b0, 8'h41);
    tick(); tick(); tick();
    lane_disable = 1'b1;
    #1 check("dis_b3_gnt", os_gnt, 1'b0);
    tick();
    #1 check("dis_b3_abort", abort, 1'b1);
    check("dis_b3_valid", tx_valid, 1'b0);
    check("dis_b3_busy", busy, 1'b0);
    set_src(1, 1'b0, 1'b0, '0);
    lane_disable = 1'b0;
    tick(); tick();
    check("dis_b3_os", n_os, 2);
    check("dis_b3_aborts", n_abort, 1);

    // Reset pulse in the middle of a TP packet
    clr_mon();
    set_src(3, 1'b1, 1'b0, 8'h77);
    tick(); tick(); tick();
    rst = 1'b0;
    #1 check("rstm_valid", tx_valid, 1'b0);
    check("rstm_data", tx_data, 8'h00);
    check("rstm_src", tx_src, 2'b00);
    check("rstm_busy", busy, 1'b0);
    check("rstm_gnt", tp_gnt, 1'b0);
    check("rstm_abort", abort, 1'b0);
    tick();
    rst = 1'b1;
    set_src(3, 1'b0, 1'b0, '0);
    set_src(1, 1'b1, 1'b1, 8'h99);
    tick();
    #1 check("rstm_os_gnt", os_gnt, 1'b1);
    tick();
    set_src(1, 1'b0, 1'b0, '0);
    tick(); tick();
    check("rstm_aborts", n_abort, 0);
    check("rstm_os_count", n_os, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/tx_lane_scheduler.md
TX_LANE_SCHEDULER -- requirements
Module: tx_lane_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the beat width of every requester and of the output datapath.
REQ-002 SHALL have parameter MAX_PKT, default 64, meaning the maximum number of beats in one packet before the packet is aborted.
REQ-003 SHALL have parameter STARVE_LIMIT, default 32, meaning the number of waiting cycles after which transport is promoted above control.
REQ-004 SHALL have port local_clk  input  1  as the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  as the asynchronous, active-low reset.
REQ-006 SHALL have port cl0_s  input  1  meaning the link is in CL0; transport and control are eligible only while it is high.
REQ-007 SHALL have port lane_disable  input  1  meaning a forced abort to idle with all grants blocked.
REQ-008 SHALL have ports os_req/os_last (1 bit each) and os_data (DATA_W) as inputs, for the ordered-set requester (highest priority).
REQ-009 SHALL have ports ctl_req/ctl_last (1 bit each) and ctl_data (DATA_W) as inputs, for the link-management requester.
REQ-010 SHALL have ports tp_req/tp_last (1 bit each) and tp_data (DATA_W) as inputs, for the transport-layer requester.
REQ-011 SHALL have outputs os_gnt, ctl_gnt, tp_gnt (1 bit each): beat accepted this cycle.
REQ-012 SHALL have outputs tx_valid (1), tx_data (DATA_W), tx_src (2: 00 none, 01 OS, 10 CTL, 11 TP), abort (1-cycle pulse) and busy (1: state not IDLE).

Function
REQ-013 SHALL implement FSM states IDLE, OS, CTL and TP, with a state encoding internal to the block.
REQ-014 From IDLE, SHALL select the next owner in this order, entering that state on the next edge:
- os_req;
- else, if cl0_s=1: tp_req when the starvation counter is at or above STARVE_LIMIT;
- else ctl_req;
- else tp_req;
- else remain in IDLE.
REQ-015 SHALL drive x_gnt combinationally as (state==X) AND x_req AND NOT lane_disable; at most one gnt is high in any cycle.
REQ-016 On each grant, SHALL register output the next cycle (latency 1): tx_valid=1, tx_data=the granted data, tx_src=the owner code; otherwise tx_valid=0, tx_data=0, tx_src=00.
REQ-017 Packets SHALL be atomic; once owned, no other requester is granted until the owner's last beat, even if cl0_s falls mid-packet.
REQ-018 If the owner deasserts req mid-packet, the FSM SHALL hold its state with gnt=0 and the beat counter frozen (stall, no timeout).
REQ-019 A grant with x_last=1 SHALL return the FSM to IDLE on the next edge, which enforces a minimum 1-cycle tx_valid gap between packets.
REQ-020 SHALL keep a beat counter (width clog2(MAX_PKT+1)) that increments per grant and clears on entry to IDLE.
REQ-021 A grant that would make the count equal MAX_PKT without x_last SHALL be forwarded, then SHALL pulse abort for 1 cycle and return the FSM to IDLE.
REQ-022 SHALL keep a saturating starvation counter:
- increments each cycle tp_req=1 while state!=TP;
- clears on TP entry or when tp_req=0;
- saturates at STARVE_LIMIT.
REQ-023 lane_disable=1 SHALL force the FSM to IDLE on the next edge and clear both counters.
REQ-024 If lane_disable interrupts a packet (state!=IDLE), SHALL pulse abort for 1 cycle; no new owner is selected while lane_disable=1.
REQ-025 When os_req and lane_disable rise in the same cycle in IDLE, lane_disable SHALL win and no grant is issued.

Reset
REQ-026 While rst=0, SHALL hold state=IDLE, all gnt=0, tx_valid=0, tx_data=0, tx_src=00, abort=0, busy=0 and both counters=0, asynchronously.
REQ-027 After rst deasserts, arbitration SHALL begin on the first rising edge; a packet in flight at reset assertion is discarded with no abort pulse.

Verification
REQ-028 SHALL cover: cl0_s=0, os_req with 4 beats (last on beat 4), tp_req held -> only os_gnt; tx_src=01 for 4 cycles starting 1 cycle later; tp never granted.
REQ-029 SHALL cover: cl0_s=1, ctl_req and tp_req raised together, each sending 2-beat packets -> CTL packet, 1-cycle gap, then TP packet; tx_src sequence 10,10,00,11,11.
REQ-030 SHALL cover: tp_req held 32 cycles behind continuous ctl traffic -> TP is granted at the next IDLE ahead of the pending ctl_req.
REQ-031 SHALL cover: TP packet of 64 beats with no tp_last -> 64 tx_valid beats, abort pulse on the cycle after beat 64, busy=0.
REQ-032 SHALL cover: lane_disable asserted on beat 3 of an OS packet -> os_gnt=0 that cycle, abort=1 next cycle, tx_valid=0, state IDLE.
REQ-033 SHALL cover: rst pulsed low mid-TP-packet -> all outputs 0 immediately; after release, a fresh os_req is granted within 1 cycle.
